// File: rtl/ram_arbiter_pkg.sv
// Shared constants and types for the two-requester RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_arbiter_pkg;

  localparam int REQ_NUM = 2;

  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  // One slot of the response shift register: which requester issued it and
  // whether it expects read data back.
  typedef struct packed {
    logic valid;
    logic is_read;
    logic id;
  } rsp_stage_t;

endpackage

// File: rtl/ram_arbiter_grant.sv
// One-hot grant between two requesters; round-robin when RAM_ARBITER_RR_EN is defined, else fixed priority to requester 0.
// Latency: combinational grant from valid bits and the registered last-granted pointer.
// Backpressure: grant is held at zero while reset is high; a grant is always an accepted handshake.
module ram_arbiter_grant
  import ram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_NUM-1:0] valid,
  output logic [REQ_NUM-1:0] grant
);

`ifdef RAM_ARBITER_RR_EN
  logic last_id;

  // Tie goes to the requester that was not granted most recently.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (valid[0] && valid[1]) begin
        grant = (last_id == REQ_ID_1) ? 2'b01 : 2'b10;
      end else begin
        grant = valid;
      end
    end
  end

  // Pointer moves only when a handshake actually completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_id <= REQ_ID_1;
    end else if (|grant) begin
      last_id <= grant[1];
    end
  end
`else
  // Only the round-robin pointer needs the clock.
  logic unused_clk;
  assign unused_clk = clk;

  // Requester 0 always wins a tie; requester 1 may starve.
  always_comb begin
    grant = '0;
    if (!reset) begin
      if (valid[0] && valid[1]) begin
        grant = 2'b01;
      end else begin
        grant = valid;
      end
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester front end for one single-port synchronous RAM (RR tie-break under RAM_ARBITER_RR_EN, fixed priority otherwise).
// Latency: command driven 1 cycle after acceptance, read data returned 3 cycles after acceptance.
// Backpressure: at most one req_ready per cycle; responses cannot be stalled.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic             req_wr_0,
  input  logic             req_wr_1,
  input  logic [DEPTH-1:0] req_addr_0,
  input  logic [DEPTH-1:0] req_addr_1,
  input  logic [WIDTH-1:0] req_wdata_0,
  input  logic [WIDTH-1:0] req_wdata_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  output logic [WIDTH-1:0] rsp_rdata_0,
  output logic [WIDTH-1:0] rsp_rdata_1,
  output logic             ram_enable,
  output logic             ram_wr_en,
  output logic [DEPTH-1:0] ram_address,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out,
  output logic             busy
);

  logic [REQ_NUM-1:0] req_valid;
  logic [REQ_NUM-1:0] grant;
  logic               acc;
  logic               sel_id;
  logic               sel_wr;
  logic [DEPTH-1:0]   sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  rsp_stage_t         stage_1;
  rsp_stage_t         stage_2;

  assign req_valid = {req_valid_1, req_valid_0};

  ram_arbiter_grant u_grant (
    .clk   (clk),
    .reset (reset),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  // Select the fields of whichever request is accepted this cycle.
  always_comb begin
    acc       = |grant;
    sel_id    = grant[1];
    sel_wr    = sel_id ? req_wr_1    : req_wr_0;
    sel_addr  = sel_id ? req_addr_1  : req_addr_0;
    sel_wdata = sel_id ? req_wdata_1 : req_wdata_0;
  end

  // Command register: one RAM access per accepted request, idle otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_enable  <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else begin
      ram_enable <= acc;
      ram_wr_en  <= acc & sel_wr;
      if (acc) begin
        ram_address <= sel_addr;
        ram_data_in <= sel_wdata;
      end
    end
  end

  // Track each issued command until the RAM's read data is available.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_1 <= '0;
      stage_2 <= '0;
    end else begin
      stage_1 <= '{valid: acc, is_read: acc & ~sel_wr, id: sel_id};
      stage_2 <= stage_1;
    end
  end

  // Register read data toward the issuing requester; data holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_0 <= 1'b0;
      rsp_valid_1 <= 1'b0;
      rsp_rdata_0 <= '0;
      rsp_rdata_1 <= '0;
    end else begin
      rsp_valid_0 <= stage_2.valid & stage_2.is_read & (stage_2.id == REQ_ID_0);
      rsp_valid_1 <= stage_2.valid & stage_2.is_read & (stage_2.id == REQ_ID_1);
      if (stage_2.valid && stage_2.is_read && stage_2.id == REQ_ID_0) begin
        rsp_rdata_0 <= ram_data_out;
      end
      if (stage_2.valid && stage_2.is_read && stage_2.id == REQ_ID_1) begin
        rsp_rdata_1 <= ram_data_out;
      end
    end
  end

  assign busy = ram_enable | stage_1.valid | stage_2.valid;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
// Latency: expects read data 3 cycles after acceptance.
// Backpressure: requesters hold requests until accepted.
module tb_ram_arbiter;

  logic       clk;
  logic       reset;
  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic       req_wr_0, req_wr_1;
  logic [3:0] req_addr_0, req_addr_1;
  logic [7:0] req_wdata_0, req_wdata_1;
  logic       rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_rdata_0, rsp_rdata_1;
  logic       ram_enable, ram_wr_en;
  logic [3:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_wr_0(req_wr_0), .req_wr_1(req_wr_1),
    .req_addr_0(req_addr_0), .req_addr_1(req_addr_1),
    .req_wdata_0(req_wdata_0), .req_wdata_1(req_wdata_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_rdata_0(rsp_rdata_0), .rsp_rdata_1(rsp_rdata_1),
    .ram_enable(ram_enable), .ram_wr_en(ram_wr_en),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM that the arbiter sits in front of.
  logic [7:0] ram_mem [16];
  initial begin
    for (int i = 0; i < 16; i++) ram_mem[i] = 8'h00;
    ram_data_out = 8'h00;
  end
  always @(posedge clk) begin
    if (ram_enable) begin
      if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
      else           ram_data_out <= ram_mem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int       due;
    bit       id;
    bit [7:0] data;
  } exp_rsp_t;

  exp_rsp_t   exp_q[$];
  bit [7:0]   shadow [16];
  bit [7:0]   exp_rdata [2];
  bit         rr_last = 1'b1;
  int         cyc = 0;
  int         last_acc = -100;
  bit         last_wr;
  bit [3:0]   last_addr;
  bit [7:0]   last_wdata;
  bit         prev_rst = 1'b0;

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
  end

  always @(negedge clk) begin
    bit       v0, v1, e_rdy0, e_rdy1, ev0, ev1, aid, awr;
    bit [3:0] aaddr;
    bit [7:0] adata;
    cyc++;
    v0 = (req_valid_0 === 1'b1);
    v1 = (req_valid_1 === 1'b1);
    e_rdy0 = 1'b0;
    e_rdy1 = 1'b0;
    if (reset !== 1'b1) begin
      if (v0 && v1) begin
`ifdef RAM_ARBITER_RR_EN
        if (rr_last) e_rdy0 = 1'b1; else e_rdy1 = 1'b1;
`else
        e_rdy0 = 1'b1;
`endif
      end else begin
        e_rdy0 = v0;
        e_rdy1 = v1;
      end
    end
    chk("req_ready_0", req_ready_0, e_rdy0);
    chk("req_ready_1", req_ready_1, e_rdy1);

    ev0 = 1'b0;
    ev1 = 1'b0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      if (exp_q[0].id) ev1 = 1'b1; else ev0 = 1'b1;
      exp_rdata[exp_q[0].id] = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    chk("rsp_valid_0", rsp_valid_0, ev0);
    chk("rsp_valid_1", rsp_valid_1, ev1);
    chk("rsp_rdata_0", rsp_rdata_0, exp_rdata[0]);
    chk("rsp_rdata_1", rsp_rdata_1, exp_rdata[1]);

    chk("ram_enable", ram_enable, (last_acc == cyc - 1));
    chk("busy", busy, (cyc - last_acc >= 1) && (cyc - last_acc <= 2));
    if (last_acc == cyc - 1) begin
      chk("ram_wr_en", ram_wr_en, last_wr);
      chk("ram_address", ram_address, last_addr);
      chk("ram_data_in", ram_data_in, last_wdata);
    end
    if (prev_rst) begin
      chk("post_reset_wr_en", ram_wr_en, 0);
      chk("post_reset_address", ram_address, 0);
      chk("post_reset_data_in", ram_data_in, 0);
    end

    // Record a handshake completing at the coming edge.
    if (e_rdy0 || e_rdy1) begin
      aid   = e_rdy1;
      awr   = aid ? req_wr_1    : req_wr_0;
      aaddr = aid ? req_addr_1  : req_addr_0;
      adata = aid ? req_wdata_1 : req_wdata_0;
      last_acc   = cyc;
      last_wr    = awr;
      last_addr  = aaddr;
      last_wdata = adata;
      rr_last    = aid;
      if (awr) shadow[aaddr] = adata;
      else     exp_q.push_back('{due: cyc + 3, id: aid, data: shadow[aaddr]});
    end

    prev_rst = (reset === 1'b1);
    if (reset === 1'b1) begin
      exp_q.delete();
      last_acc = -100;
      rr_last = 1'b1;
      exp_rdata[0] = 8'h00;
      exp_rdata[1] = 8'h00;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input bit wr, input bit [3:0] a, input bit [7:0] d);
    bit got = 1'b0;
    if (id) begin
      req_valid_1 = 1'b1; req_wr_1 = wr; req_addr_1 = a; req_wdata_1 = d;
    end else begin
      req_valid_0 = 1'b1; req_wr_0 = wr; req_addr_0 = a; req_wdata_0 = d;
    end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? (req_ready_1 === 1'b1) : (req_ready_0 === 1'b1);
      step();
    end
    chk("issue_accepted", got, 1'b1);
    if (id) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rdy0_n, rdy1_n, rsp0_n, rsp1_n;
    bit a0, a1;
    reset = 1'b1;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_wr_0 = 1'b0; req_wr_1 = 1'b0;
    req_addr_0 = 4'h0; req_addr_1 = 4'h0;
    req_wdata_0 = 8'h00; req_wdata_1 = 8'h00;
    repeat (3) step();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    step();
    @(negedge clk);
    chk("reset_ready_0", req_ready_0, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rdata_0", rsp_rdata_0, 0);
    step();
    reset = 1'b0;

    // Write then read back from requester 0.
    issue(0, 1, 4'd3, 8'hA5);
    issue(0, 0, 4'd3, 8'h00);
    repeat (3) @(negedge clk);
    chk("wr_rd_valid_0", rsp_valid_0, 1);
    chk("wr_rd_data_0", rsp_rdata_0, 8'hA5);
    step();

    // Preload then both requesters read continuously for 10 cycles.
    issue(0, 1, 4'd1, 8'h11);
    issue(1, 1, 4'd2, 8'h22);
    step();
    req_valid_0 = 1'b1; req_wr_0 = 1'b0; req_addr_0 = 4'd1;
    req_valid_1 = 1'b1; req_wr_1 = 1'b0; req_addr_1 = 4'd2;
    rdy0_n = 0; rdy1_n = 0; rsp0_n = 0; rsp1_n = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rdy0_n += int'(req_ready_0);
      rdy1_n += int'(req_ready_1);
      rsp0_n += int'(rsp_valid_0);
      rsp1_n += int'(rsp_valid_1);
      step();
      if (i == 9) begin
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
      end
    end
`ifdef RAM_ARBITER_RR_EN
    chk("tie_ready_1_count", rdy1_n, 5);
    chk("tie_rsp_0_count", rsp0_n, 5);
    chk("tie_rsp_1_count", rsp1_n, 5);
`else
    chk("tie_ready_1_count", rdy1_n, 0);
    chk("tie_rsp_0_count", rsp0_n, 10);
    chk("tie_rsp_1_count", rsp1_n, 0);
`endif
    chk("tie_ready_0_count", rdy0_n + rdy1_n, 10);

    // Write from requester 1 followed by a read from requester 0.
    issue(1, 1, 4'd7, 8'h3C);
    issue(0, 0, 4'd7, 8'h00);
    repeat (3) @(negedge clk);
    chk("hazard_valid_0", rsp_valid_0, 1);
    chk("hazard_data_0", rsp_rdata_0, 8'h3C);
    step();

    // Idle: nothing issued, outputs hold.
    repeat (5) begin
      @(negedge clk);
      chk("idle_enable", ram_enable, 0);
      chk("idle_busy", busy, 0);
      chk("idle_rdata_0", rsp_rdata_0, 8'h3C);
`ifdef RAM_ARBITER_RR_EN
      chk("idle_rdata_1", rsp_rdata_1, 8'h22);
`else
      chk("idle_rdata_1", rsp_rdata_1, 8'h00);
`endif
      step();
    end

    // Reset one cycle after a read is accepted.
    issue(0, 0, 4'd3, 8'h00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_enable", ram_enable, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata_0", rsp_rdata_0, 0);
    chk("rst_mid_rdata_1", rsp_rdata_1, 0);
    step();
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", {rsp_valid_1, rsp_valid_0}, 0);
      step();
    end

    // Random traffic; requests held until accepted.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a0 = req_valid_0 && req_ready_0;
      a1 = req_valid_1 && req_ready_1;
      step();
      if (!req_valid_0 || a0) begin
        req_valid_0 = ($urandom_range(0, 2) != 0);
        req_wr_0    = $urandom_range(0, 1) != 0;
        req_addr_0  = 4'($urandom_range(0, 15));
        req_wdata_0 = 8'($urandom_range(0, 255));
      end
      if (!req_valid_1 || a1) begin
        req_valid_1 = ($urandom_range(0, 2) != 0);
        req_wr_1    = $urandom_range(0, 1) != 0;
        req_addr_1  = 4'($urandom_range(0, 15));
        req_wdata_1 = 8'($urandom_range(0, 255));
      end
    end
    // Let the last accepted request (if any) complete, then drain.
    @(negedge clk);
    step();
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    repeat (6) step();
    @(negedge clk);
    chk("drain_pending_responses", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester access controller for the single-port synchronous `RAM` block. It arbitrates between requester 0 and requester 1 with a valid/ready handshake and drives registered RAM command signals. It returns read data to the issuing requester with fixed latency. It sits directly in front of one `RAM` instance and is the only master driving that RAM's `enable`, `wr_en`, `address` and `data_in`.

## Interface
- `DEPTH`, default 4: RAM address width, giving 2**DEPTH words; must match the RAM's `DEPTH`.
- `WIDTH`, default 8: data width; must match the RAM's `WIDTH`.

Ports, with clock and reset first:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_valid_0` / `req_valid_1`  in  1: request present.
- `req_ready_0` / `req_ready_1`  out  1: request accepted this cycle.
- `req_wr_0` / `req_wr_1`  in  1: 1 = write, 0 = read.
- `req_addr_0` / `req_addr_1`  in  DEPTH: word address.
- `req_wdata_0` / `req_wdata_1`  in  WIDTH: write data.
- `rsp_valid_0` / `rsp_valid_1`  out  1: read data valid, one-cycle pulse.
- `rsp_rdata_0` / `rsp_rdata_1`  out  WIDTH: read data; holds its last value between responses.
- `ram_enable`  out  1: to RAM `enable`.
- `ram_wr_en`  out  1: to RAM `wr_en`.
- `ram_address`  out  DEPTH: to RAM `address`.
- `ram_data_in`  out  WIDTH: to RAM `data_in`.
- `ram_data_out`  in  WIDTH: from RAM `data_out`.
- `busy`  out  1: a command or a read response is in flight.

## Operation
- Handshake completes on a rising edge where `req_valid_i` and `req_ready_i` are both 1.
  - At most one `req_ready_i` is high per cycle.
  - `req_ready_i` depends only on both `req_valid` inputs and registered state.
  - Once `req_valid_i` is raised, the requester holds it and all request fields stable until accepted.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: the grant follows the policy described under Configuration.
  - No requester valid: no grant, and `ram_enable` is 0 in the following cycle.
- Command stage:
  - Registered `ram_enable`, `ram_wr_en`, `ram_address` and `ram_data_in` load from the accepted request.
  - `ram_enable` deasserts when no request is accepted.
  - Throughput is one access per cycle, with back-to-back grants allowed.
- Response stage:
  - A 2-deep shift register carries {read, requester id} for each issued command.
  - When a read reaches stage 2, the addressed requester gets `rsp_valid_i` = 1 for one cycle, and `rsp_rdata_i` loads `ram_data_out`.
  - Writes produce no response.
- Responses cannot be back-pressured; requesters always accept them.
- Ordering: accesses reach the RAM in grant order. A write granted before a read to the same address is visible to that read; there is no bypass logic, because the RAM serialises the accesses.
- `busy` = `ram_enable` OR any valid stage in the response shift register.

## Timing
- Request accepted at the end of cycle N.
- `ram_*` command is driven during cycle N+1.
- The RAM samples the command at the end of N+1.
- `ram_data_out` is valid in cycle N+2 and registered at the end of N+2.
- `rsp_valid_i` and the new `rsp_rdata_i` are visible in cycle N+3, giving a read latency of 3 cycles from acceptance.
- Reset values:
  - `req_ready_*`: 0 while `reset` is high.
  - `rsp_valid_*`, `ram_enable`, `ram_wr_en`, `busy`: 0.
  - `ram_address`, `ram_data_in`, `rsp_rdata_*`: 0.
  - Round-robin pointer: "last granted = 1", so requester 0 wins the first tie.
- Reset mid-operation clears all pipeline stages. In-flight reads are dropped and produce no `rsp_valid`. A write already presented to the RAM in the reset cycle is not recalled.
- Address wrap: none inside the block; the address is passed through unmodified.

## Configuration
- `RAM_ARBITER_RR_EN` defined:
  - Round-robin. On a tie, grant the requester not granted most recently.
  - The last-granted pointer updates only on an accepted handshake.
- Not defined:
  - Fixed priority: requester 0 always wins a tie.
  - No pointer register exists; requester 1 can starve.

## Structure
- Package `ram_arbiter_pkg` holds:
  - `REQ_NUM` = 2.
  - Requester id constants `REQ_ID_0` = 0 and `REQ_ID_1` = 1.
  - The response-stage struct type {valid, is_read, id}.
- One sub-module, `ram_arbiter_grant`:
  - Takes the two valid bits and the pointer, and produces the one-hot grant.
  - Contains the round-robin pointer under `RAM_ARBITER_RR_EN`.

## Test plan
- Write, then read back:
  - Requester 0 writes addr 3 = 0xA5 in cycle 1, then reads addr 3 in cycle 2.
  - Expect `rsp_valid_0` in cycle 5 with `rsp_rdata_0` = 0xA5, and `rsp_valid_1` never asserted.
- Simultaneous reads, RR build:
  - Both requesters read continuously: req 0 addr 1 (0x11), req 1 addr 2 (0x22).
  - Expect grants to alternate 0,1,0,1, and responses to alternate in the same order 3 cycles after each grant.
- Same stimulus, fixed-priority build: expect `req_ready_1` = 0 for all 10 cycles and ten `rsp_valid_0` pulses.
- Cross-requester hazard:
  - Requester 1 writes addr 7 = 0x3C, and requester 0 reads addr 7 in the next cycle.
  - Expect `rsp_rdata_0` = 0x3C.
- Reset mid-read:
  - Assert `reset` one cycle after a read is accepted.
  - Expect no `rsp_valid`, all outputs 0, and `busy` = 0 in the cycle after reset releases.
- Idle: with no valids for 5 cycles, expect `ram_enable` = 0, `busy` = 0, and `rsp_rdata_*` holding its previous values.
